// File: rtl/if_id_queue_pkg.sv
// Shared definitions for the fetch/decode stage: opcodes, instruction field
// positions and dec_ctrl bit positions.
package if_id_queue_pkg;

  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_ARITHI   = 7'b0010011;
  localparam logic [6:0] OP_ARITHR   = 7'b0110011;
  localparam logic [6:0] OP_CUSTOM   = 7'b0001011;
  localparam logic [6:0] OP_CONV_JAL = 7'b1011011;

  localparam int OPCODE_LSB  = 0;
  localparam int OPCODE_MSB  = 6;
  localparam int RD_LSB      = 7;
  localparam int RD_MSB      = 11;
  localparam int FUNC3_LSB   = 12;
  localparam int FUNC3_MSB   = 14;
  localparam int RS1_LSB     = 15;
  localparam int RS1_MSB     = 19;
  localparam int RS2_LSB     = 20;
  localparam int RS2_MSB     = 24;
  localparam int SUBTYPE_BIT = 30;

  localparam int CTRL_IMM_SEL    = 7;
  localparam int CTRL_ALU        = 6;
  localparam int CTRL_LUI        = 5;
  localparam int CTRL_JAL        = 4;
  localparam int CTRL_JALR       = 3;
  localparam int CTRL_BRANCH     = 2;
  localparam int CTRL_MEM_WRITE  = 1;
  localparam int CTRL_MEM_TO_REG = 0;

endpackage

// File: rtl/if_id_fifo.sv
// Prefetch queue: DEPTH entries of W bits, power-of-two depth so the
// pointers wrap naturally; a separate count tells full from empty.
module if_id_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 64,
  localparam int AW   = $clog2(DEPTH),
  localparam int CW   = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  input  logic [W-1:0]  wdata_i,
  output logic [W-1:0]  rdata_o,
  output logic          full_o,
  output logic          empty_o,
  output logic [CW-1:0] count_o
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          do_push, do_pop;

  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign count_o = cnt_q;
  assign rdata_o = mem_q[rd_q];
  assign do_push = push_i && !full_o && !flush_i;
  assign do_pop  = pop_i && !empty_o && !flush_i;

  // Next pointers and occupancy; flush empties the queue outright.
  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush_i) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      case ({do_push, do_pop})
        2'b10:   cnt_d = cnt_q + CW'(1);
        2'b01:   cnt_d = cnt_q - CW'(1);
        default: cnt_d = cnt_q;
      endcase
    end
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
    end
  end

  // Storage array; contents are meaningless while the count says empty.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_q] <= wdata_i;
  end

endmodule

// File: rtl/if_id_queue.sv
// Fetch/decode stage: prefetch queue, decoder on the queue head, registered
// output slot with valid/ready, sticky fault capture and the integer
// register file. Optional macro IF_ID_WB_BYPASS_EN forwards a same-cycle
// write-back onto rdata1/rdata2.
module if_id_queue
  import if_id_queue_pkg::*;
#(
  parameter int              XLEN     = 32,
  parameter int              DEPTH    = 4,
  parameter int              NREGS    = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            inst_valid,
  input  logic [31:0]     inst_data,
  input  logic [XLEN-1:0] inst_pc,
  output logic            inst_ready,
  input  logic            flush,
  output logic            dec_valid,
  input  logic            dec_ready,
  output logic [XLEN-1:0] dec_pc,
  output logic [XLEN-1:0] dec_imm,
  output logic [4:0]      dec_rs1,
  output logic [4:0]      dec_rs2,
  output logic [4:0]      dec_rd,
  output logic [2:0]      dec_func3,
  output logic            dec_subtype,
  output logic [7:0]      dec_ctrl,
  output logic            dec_illegal,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            wb_valid,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
  output logic            exception,
  output logic [XLEN-1:0] exception_pc
);

  localparam int CW = $clog2(DEPTH + 1);
  localparam int RW = $clog2(NREGS);

  logic [XLEN+31:0] head;
  logic             q_full, q_empty, push, load;
  logic [CW-1:0]    unused_count;
  logic [31:0]      ins;
  logic [XLEN-1:0]  hpc;

  assign inst_ready = !q_full;
  assign push       = inst_valid && inst_ready && !flush;
  assign load       = !q_empty && (!dec_valid || dec_ready) && !flush;
  assign ins        = head[31:0];
  assign hpc        = head[XLEN+31:32];

  if_id_fifo #(.DEPTH(DEPTH), .W(XLEN + 32)) u_fifo (
    .clk_i   (clk),
    .rst_i   (reset),
    .flush_i (flush),
    .push_i  (push),
    .pop_i   (load),
    .wdata_i ({inst_pc, inst_data}),
    .rdata_o (head),
    .full_o  (q_full),
    .empty_o (q_empty),
    .count_o (unused_count)
  );

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic [6:0]      opcode;
  logic [2:0]      f3;
  logic [7:0]      ctrl_raw, ctrl_d;
  logic [XLEN-1:0] imm_d, shamt;
  logic            known, use_shamt, illegal_d, subtype_d;
  logic [31:0]     imm32;

  // Decode the queue head: control bits, immediate and legality.
  always_comb begin
    opcode    = ins[OPCODE_MSB:OPCODE_LSB];
    f3        = ins[FUNC3_MSB:FUNC3_LSB];
    ctrl_raw  = '0;
    imm32     = '0;
    known     = 1'b1;
    use_shamt = 1'b0;
    shamt     = '0;
    shamt[4:0] = ins[24:20];
    if (XLEN == 64) shamt[5] = ins[25];
    case (opcode)
      OP_LUI: begin
        ctrl_raw[CTRL_LUI] = 1'b1;  ctrl_raw[CTRL_IMM_SEL] = 1'b1;
        imm32 = {ins[31:12], 12'b0};
      end
      OP_JAL, OP_CONV_JAL: begin
        ctrl_raw[CTRL_JAL] = 1'b1;
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OP_JALR: begin
        ctrl_raw[CTRL_JALR] = 1'b1; ctrl_raw[CTRL_IMM_SEL] = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      OP_BRANCH: begin
        ctrl_raw[CTRL_BRANCH] = 1'b1;
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OP_LOAD: begin
        ctrl_raw[CTRL_MEM_TO_REG] = 1'b1; ctrl_raw[CTRL_IMM_SEL] = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      OP_STORE: begin
        ctrl_raw[CTRL_MEM_WRITE] = 1'b1; ctrl_raw[CTRL_IMM_SEL] = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OP_ARITHI: begin
        ctrl_raw[CTRL_ALU] = 1'b1; ctrl_raw[CTRL_IMM_SEL] = 1'b1;
        imm32 = {{20{ins[31]}}, ins[31:20]};
        use_shamt = (f3 == 3'b101);
      end
      OP_ARITHR, OP_CUSTOM: ctrl_raw[CTRL_ALU] = 1'b1;
      default: known = 1'b0;
    endcase
    imm_d     = use_shamt ? shamt : sext32(imm32);
    subtype_d = (opcode == OP_ARITHI && f3 == 3'b000) ? 1'b0 : ins[SUBTYPE_BIT];
    illegal_d = !known || (hpc[1:0] != 2'b00) ||
                ((NREGS == 16) && (ins[RD_MSB] || ins[RS1_MSB] || ins[RS2_MSB]));
    ctrl_d    = illegal_d ? 8'h00 : ctrl_raw;
  end

  // Output slot: load the decoded head, drop valid when consumed and empty.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dec_valid <= 1'b0;    dec_pc    <= RESET_PC;  dec_imm     <= '0;
      dec_rs1   <= '0;      dec_rs2   <= '0;        dec_rd      <= '0;
      dec_func3 <= '0;      dec_ctrl  <= '0;        dec_subtype <= 1'b0;
      dec_illegal <= 1'b0;
    end else if (flush) begin
      dec_valid <= 1'b0;
    end else if (load) begin
      dec_valid   <= 1'b1;
      dec_pc      <= hpc;
      dec_imm     <= imm_d;
      dec_rs1     <= ins[RS1_MSB:RS1_LSB];
      dec_rs2     <= ins[RS2_MSB:RS2_LSB];
      dec_rd      <= ins[RD_MSB:RD_LSB];
      dec_func3   <= f3;
      dec_subtype <= subtype_d;
      dec_ctrl    <= ctrl_d;
      dec_illegal <= illegal_d;
    end else if (dec_ready) begin
      dec_valid <= 1'b0;
    end
  end

  // Sticky fault flag; the pc of the first faulting slot load is kept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      exception    <= 1'b0;
      exception_pc <= '0;
    end else if (load && illegal_d) begin
      exception <= 1'b1;
      if (!exception) exception_pc <= hpc;
    end
  end

  logic [XLEN-1:0] regs_q [NREGS];

  // Register file write port; x0 and out-of-range indices are ignored.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NREGS; i++) regs_q[i] <= '0;
    end else if (wb_valid && wb_rd != 5'd0 && 32'(wb_rd) < NREGS) begin
      regs_q[wb_rd[RW-1:0]] <= wb_data;
    end
  end

  function automatic logic [XLEN-1:0] rf_read(input logic [4:0] idx);
    if (idx == 5'd0 || 32'(idx) >= NREGS) return '0;
    return regs_q[idx[RW-1:0]];
  endfunction

  // Operand read for the slot's source registers.
  always_comb begin
`ifdef IF_ID_WB_BYPASS_EN
    rdata1 = (wb_valid && wb_rd != 5'd0 && wb_rd == dec_rs1) ? wb_data : rf_read(dec_rs1);
    rdata2 = (wb_valid && wb_rd != 5'd0 && wb_rd == dec_rs2) ? wb_data : rf_read(dec_rs2);
`else
    rdata1 = rf_read(dec_rs1);
    rdata2 = rf_read(dec_rs2);
`endif
  end

endmodule

// File: doc/if_id_queue.md
Name: if_id_queue

Overview:
Parametrised fetch/decode stage for the RISC-V-DSP core.
- Sits between instruction memory and the execute stage.
- Buffers fetched words in a prefetch queue of depth DEPTH, decodes the queue head, and holds the result in a registered output slot.
- Hands decoded instructions to execute with a valid/ready handshake, and owns the integer register file including write-back bypass.
- Generalised over XLEN, queue depth and register count (RV32E-style 16 registers).

Parameters:
- XLEN, 32: register and immediate width; 32 or 64; immediates sign-extend to XLEN.
- DEPTH, 4: prefetch queue entries; power of two, at least 2.
- NREGS, 32: architectural registers; 16 or 32.
- RESET_PC, 0: value of dec_pc after reset.

Ports:
- clk  in  1  core clock.
- reset  in  1  asynchronous, active-high reset.
- inst_valid  in  1  fetch word is valid.
- inst_data  in  32  instruction word.
- inst_pc  in  XLEN  pc of inst_data.
- inst_ready  out  1  queue can accept a word.
- flush  in  1  discard the queue and the output slot (redirect).
- dec_valid  out  1  output slot holds a decoded instruction.
- dec_ready  in  1  execute accepts the slot.
- dec_pc  out  XLEN  pc of the decoded instruction.
- dec_imm  out  XLEN  decoded immediate.
- dec_rs1, dec_rs2, dec_rd  out  5 each  register indices.
- dec_func3  out  3  instruction bits 14:12.
- dec_subtype  out  1  bit 30, forced 0 for ARITHI ADD.
- dec_ctrl  out  8  {imm_sel, alu, lui, jal, jalr, branch, mem_write, mem_to_reg}.
- dec_illegal  out  1  slot holds an illegal or misaligned instruction.
- rdata1, rdata2  out  XLEN  operands for dec_rs1 / dec_rs2.
- wb_valid  in  1  write-back request.
- wb_rd  in  5  write-back destination.
- wb_data  in  XLEN  write-back value.
- exception  out  1  sticky fault flag.
- exception_pc  out  XLEN  pc of the first fault.

Behaviour:
Reset
- All outputs are 0 except dec_pc=RESET_PC and inst_ready=1.
- Queue is empty; registers 1..NREGS-1 are 0.
- Reset asserted mid-operation discards all state asynchronously.

Queue
- Push when inst_valid && inst_ready; inst_ready = !full.
- No push when full, even if a pop happens in the same cycle.
- Read and write pointers wrap modulo DEPTH; a separate count distinguishes full from empty.

Output slot
- Loads the decoded head when the queue is not empty and (!dec_valid || dec_ready); this load pops the queue.
- If dec_ready is high and the queue is empty, dec_valid drops to 0.
- The slot holds all fields stable while dec_valid && !dec_ready.
- Minimum latency: a word pushed at edge N is presented with dec_valid=1 after edge N+1.

Flush
- Clears the queue and dec_valid at the next edge.
- Has priority over a simultaneous push or load; the pushed word is dropped.

Decode
- Immediate formats per opcode:
  - JALR, LOAD: I-type.
  - BRANCH: B-type.
  - STORE: S-type.
  - ARITHI: I-type, except func3=101 gives a zero-extended shamt (bits 24:20 when XLEN=32, bits 25:20 when XLEN=64).
  - ARITHR, CUSTOM: 0.
  - LUI: U-type, sign-extended from bit 31.
  - JAL, CONV_JAL: J-type.
- jal is set for both JAL and CONV_JAL.
- alu is set for ARITHI, ARITHR and CUSTOM.

Illegal / fault
- An instruction is illegal if:
  - its opcode is not in the set above, or
  - NREGS=16 and any of rs1, rs2 or rd is 16 or higher, or
  - inst_pc[1:0] != 0 (misaligned).
- An illegal instruction loads into the slot with dec_illegal=1 and dec_ctrl=0.
- On that load, exception is set. exception_pc captures the pc only if exception was 0. Only reset clears either.

Register file
- Written at the edge when wb_valid && wb_rd != 0.
- wb_rd >= NREGS is ignored.
- Register 0 always reads 0.
- rdata1/rdata2 are combinational from dec_rs1/dec_rs2 and the register array.

Optional Feature:
Macro: IF_ID_WB_BYPASS_EN
- Defined: if wb_valid && wb_rd == dec_rsN && wb_rd != 0 in the same cycle, rdataN returns wb_data.
- Not defined: rdataN returns the stored value, which is stale until the next edge. Execute must stall one cycle on that hazard.

Decomposition:
- Shared package: opcode constants (LUI, JAL, JALR, BRANCH, LOAD, STORE, ARITHI, ARITHR, CUSTOM=7'b0001011, CONV_JAL=7'b1011011), field ranges (OPCODE, RD, FUNC3, RS1, RS2, SUBTYPE), and the dec_ctrl bit positions.
- Sub-module if_id_fifo: parametrised DEPTH x (32+XLEN) queue with full, empty and count.
- Decode and register file stay in the top level.

Test Plan:
- Reset → dec_valid=0, dec_pc=0, inst_ready=1, exception=0, rdata1=rdata2=0.
- Push ADDI x5,x0,-1 (0xFFF00293) at pc 0 with dec_ready=1 → after 2 edges: dec_valid=1, dec_imm=0xFFFFFFFF, dec_rd=5, dec_ctrl=8'b11000000.
- Hold dec_ready=0 and push 5 words with DEPTH=4 → after 4 queue pushes plus 1 slot load, inst_ready=0; the 6th word is blocked. Release dec_ready → words appear in order and pointers wrap.
- Assert flush together with a push while the queue holds 3 words → next cycle dec_valid=0, the queue is empty, and the pushed word is never presented.
- Push opcode 0x7F, then a word at pc 0x102 → first load: exception=1, exception_pc=previous pc, dec_illegal=1. Second fault leaves exception_pc unchanged.
- Write wb_rd=3, wb_data=0x1234 while dec_rs1=3 → rdata1=0x1234 in the same cycle if IF_ID_WB_BYPASS_EN is defined, else the old value, then 0x1234 after the edge. A write to x0 leaves rdata1 at 0.
